seg_scan_receiver: RTL
======================

// Module: seg_scan_receiver
// PURPOSE
// - Receiving end of the multiplexed 7-segment scan bus (an active-low one-hot, seg active-low gfedcba).
// - Samples an/seg and decodes each lit slot back to a 4-bit digit code.
// - Assembles 4-slot frames and publishes them once stable.
// - Sits on the board-to-board scoreboard link and serves as the in-bench display monitor.
// PARAMETERS
// - SETTLE_CYC     4        clk cycles after an anode change before seg is sampled
// - STABLE_FRAMES  2        consecutive identical frames required before outputs update (>=1)
// - TIMEOUT_CYC    1000000  clk cycles without an anode change before the link is declared lost
// PORTS
// - clk        in   1  system clock (single clock domain)
// - rst        in   1  asynchronous, active-low reset
// - an_in      in   4  scanned anode lines, active-low; async to clk
// - seg_in     in   7  segment lines {g,f,e,d,c,b,a}, active-low; async to clk
// - dig0..dig3 out  4  each: decoded digit per slot (an 1110,1101,1011,0111 -> dig0..dig3)
// - frame_valid out 1  1-cycle pulse when dig0..dig3 update
// - link_ok    out  1  high while complete, in-order frames are being received
// - err_seg    out  1  1-cycle pulse on an unrecognised segment pattern
// - err_anode  out  1  1-cycle pulse on an illegal anode pattern (not one-hot-low, not 1111)
// BEHAVIOUR
// - Reset (rst=0, async): dig0..dig3=4'd10, frame_valid=0, link_ok=0, err_*=0,
//   state=HUNT, stable count=0, timeout counter=0.
// - an_in and seg_in pass through 2-FF synchronisers; all logic below uses the synchronised copies.
// - Anode change: synchronised an differs from its previous-cycle value.
//   Any anode change reloads the timeout counter.
// - Decode table:
//   - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4,
//     0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9,
//     0111111=10 (dash), 1111111=11 (blank).
//   - Any other pattern decodes to 4'd15 and pulses err_seg.
// - FSM:
//   - HUNT: wait for an=1110 -> SETTLE (slot=0).
//   - SETTLE: count SETTLE_CYC cycles.
//     - An anode change during SETTLE aborts the frame -> HUNT.
//     - Otherwise -> CAPTURE.
//   - CAPTURE (1 cycle): store the decoded seg into frame[slot] -> WAIT.
//   - WAIT: hold until an anode change.
//     - New an equals the expected next slot (rotate-left order) -> SETTLE with slot+1.
//     - After slot 3 is captured, the next slot expected is slot 0 and the frame is complete -> COMMIT.
//     - Wrong slot, or an=1111 (all off) -> HUNT.
//     - Illegal anode pattern: pulse err_anode -> HUNT.
//   - COMMIT (1 cycle):
//     - Frame equal to the previous frame -> stable count increments (saturating); otherwise it reloads to 1.
//     - Stable count reaching STABLE_FRAMES -> dig* <= frame, frame_valid=1 in this cycle, link_ok=1.
//     - Then -> SETTLE for slot 0 (no HUNT, since an=1110 is already present).
// - Latency: frame_valid fires 1 cycle after COMMIT is entered.
//   COMMIT is entered 1 clk after the slot-0 anode edge that follows capture of slot 3, plus 2 sync cycles.
// - Loss of sync, in these cases:
//   - timeout expiry
//   - any abort to HUNT
//   - err_seg in a captured slot
//   Each of these clears the stable count and drops link_ok. dig* hold their last published values.
// - A frame containing code 15 is never published.
// - Simultaneous events: err_anode takes priority over err_seg. An abort in the same cycle as a timeout counts as one loss.
// CONFIGURATION
// - SEG_RX_ERR_COUNT_EN defined:
//   - Adds port err_count (out, 8): saturating count of err_seg + err_anode pulses + timeouts.
//   - Reset value 0; holds at 255.
// - SEG_RX_ERR_COUNT_EN undefined: no port, no counter; all other behaviour is identical.
// STRUCTURE
// - Shared package seg_pkg:
//   - segment pattern constants
//   - digit codes (DASH=10, BLANK=11, BAD=15)
//   - anode slot constants
//   - FSM state encoding (HUNT, SETTLE, CAPTURE, WAIT, COMMIT)
// - Sub-module seg_pattern_decode: combinational 7-bit pattern -> {code[3:0], bad}. Instantiated once.
// TESTING
// - Frame publish: reset, then drive the scan of "0 1 2 3" for 2 full rotations
//   -> frame_valid pulses once; dig0..3 = 0,1,2,3; link_ok = 1.
// - Stability gate: alternate scans of "5 5 5 5" and "5 5 5 6" each rotation -> no frame_valid; dig* stay 10.
// - Out-of-order slot: an goes 1110 -> 1011 -> err-free abort to HUNT; link_ok = 0; the next 2 clean frames republish.
// - Bad inputs:
//   - seg = 1010101 in slot 2 -> err_seg pulse; that frame is not published.
//   - an = 1100 -> err_anode pulse.
// - Timeout: freeze an for TIMEOUT_CYC + 1 cycles -> link_ok falls; dig* hold their values.
//   With SEG_RX_ERR_COUNT_EN, err_count increments by 1.
// - Reset mid-frame: assert rst during SETTLE of slot 2 -> all outputs return to reset values immediately; HUNT.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan receiver: segment patterns, digit codes,
// anode slot patterns, FSM state encoding and small helpers.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] DIG_DASH  = 4'd10;
   localparam logic [3:0] DIG_BLANK = 4'd11;
   localparam logic [3:0] DIG_BAD   = 4'd15;

   localparam logic [3:0] AN_SLOT0 = 4'b1110;
   localparam logic [3:0] AN_SLOT1 = 4'b1101;
   localparam logic [3:0] AN_SLOT2 = 4'b1011;
   localparam logic [3:0] AN_SLOT3 = 4'b0111;
   localparam logic [3:0] AN_OFF   = 4'b1111;

   typedef enum logic [2:0] {HUNT, SETTLE, CAPTURE, WAIT, COMMIT} rx_state_t;

   function automatic logic [3:0] slot_an(input logic [1:0] slot);
      logic [3:0] an;
      case (slot)
         2'd0:    an = AN_SLOT0;
         2'd1:    an = AN_SLOT1;
         2'd2:    an = AN_SLOT2;
         default: an = AN_SLOT3;
      endcase
      return an;
   endfunction

   function automatic logic an_legal(input logic [3:0] an);
      return (an == AN_OFF) || (an == AN_SLOT0) || (an == AN_SLOT1) ||
             (an == AN_SLOT2) || (an == AN_SLOT3);
   endfunction

   function automatic logic frame_has_bad(input logic [15:0] frame);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (frame[4*i +: 4] == DIG_BAD) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low {g,f,e,d,c,b,a} pattern to a digit code;
// unknown patterns give DIG_BAD with bad set.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       bad
);

   always_comb begin
      code = DIG_BAD;
      bad  = 1'b0;
      case (seg)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_DASH:  code = DIG_DASH;
         SEG_BLANK: code = DIG_BLANK;
         default:   bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_receiver.sv
// Receiver for a multiplexed 7-segment scan bus: decodes slots, assembles 4-slot frames
// and publishes them once stable. Define SEG_RX_ERR_COUNT_EN to add the err_count port.
module seg_scan_receiver
   import seg_pkg::*;
#(
   parameter int SETTLE_CYC    = 4,
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT_CYC   = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] an_in,
   input  logic [6:0] seg_in,
   output logic [3:0] dig0,
   output logic [3:0] dig1,
   output logic [3:0] dig2,
   output logic [3:0] dig3,
   output logic       frame_valid,
   output logic       link_ok,
   output logic       err_seg,
`ifdef SEG_RX_ERR_COUNT_EN
   output logic       err_anode,
   output logic [7:0] err_count
`else
   output logic       err_anode
`endif
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int STB_W = $clog2(STABLE_FRAMES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_FRAMES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_DONE = TMO_W'(TIMEOUT_CYC);

   logic [3:0]       an_p0, an_p1, an_prev;
   logic [6:0]       seg_p0, seg_p1;
   rx_state_t        state, state_d;
   logic [1:0]       slot, slot_d;
   logic [SET_W-1:0] settle_cnt, settle_d;
   logic [TMO_W-1:0] tmo_cnt, tmo_d;
   logic [STB_W-1:0] stable_cnt, stable_d;
   logic [3:0][3:0]  frame_q, frame_d, prev_frame, prev_d, dig_q, dig_d;
   logic             link_d, fv_d, es_d, ea_d;
   logic             an_change, timeout, abort, same_frame;
   logic [3:0]       dec_code;
   logic             dec_bad;

   // p0/p1: two-stage synchronisers; an_prev holds the previous synchronised anode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_p0   <= AN_OFF;
         an_p1   <= AN_OFF;
         an_prev <= AN_OFF;
         seg_p0  <= SEG_BLANK;
         seg_p1  <= SEG_BLANK;
      end else begin
         an_p0   <= an_in;
         an_p1   <= an_p0;
         an_prev <= an_p1;
         seg_p0  <= seg_in;
         seg_p1  <= seg_p0;
      end
   end

   seg_pattern_decode u_decode (
      .seg  (seg_p1),
      .code (dec_code),
      .bad  (dec_bad)
   );

   assign an_change  = (an_p1 != an_prev);
   assign timeout    = !an_change && (tmo_cnt == TMO_LAST);
   assign same_frame = (frame_q == prev_frame);
   assign tmo_d      = an_change ? '0 : ((tmo_cnt == TMO_DONE) ? tmo_cnt : tmo_cnt + 1'b1);

   always_comb begin
      state_d  = state;
      slot_d   = slot;
      settle_d = settle_cnt;
      stable_d = stable_cnt;
      frame_d  = frame_q;
      prev_d   = prev_frame;
      dig_d    = dig_q;
      link_d   = link_ok;
      fv_d     = 1'b0;
      es_d     = 1'b0;
      ea_d     = 1'b0;
      abort    = 1'b0;
      case (state)
         HUNT: begin
            if (an_p1 == AN_SLOT0) begin
               state_d  = SETTLE;
               slot_d   = 2'd0;
               settle_d = '0;
            end
         end
         SETTLE: begin
            if (an_change)                  abort    = 1'b1;
            else if (settle_cnt == SET_LAST) state_d = CAPTURE;
            else                             settle_d = settle_cnt + 1'b1;
         end
         CAPTURE: begin
            frame_d[slot] = dec_code;
            if (an_change) begin
               abort = 1'b1;
            end else if (dec_bad) begin
               es_d  = 1'b1;
               abort = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (an_change) begin
               if (an_p1 != slot_an(slot + 2'd1)) begin
                  abort = 1'b1;
               end else if (slot == 2'd3) begin
                  state_d = COMMIT;
               end else begin
                  state_d  = SETTLE;
                  slot_d   = slot + 2'd1;
                  settle_d = '0;
               end
            end
         end
         COMMIT: begin
            if (an_change) begin
               abort = 1'b1;
            end else begin
               prev_d = frame_q;
               if (!same_frame)                 stable_d = STB_W'(1);
               else if (stable_cnt != STB_MAX) stable_d = stable_cnt + 1'b1;
               // Publish only on the commit that first reaches the threshold for this frame
               if ((stable_d == STB_MAX) && !(same_frame && (stable_cnt == STB_MAX)) &&
                   !frame_has_bad(frame_q)) begin
                  dig_d  = frame_q;
                  fv_d   = 1'b1;
                  link_d = 1'b1;
               end
               state_d  = SETTLE;
               slot_d   = 2'd0;
               settle_d = '0;
            end
         end
         default: state_d = HUNT;
      endcase

      if (an_change && !an_legal(an_p1)) begin
         ea_d  = 1'b1;
         es_d  = 1'b0;
         abort = 1'b1;
      end
      if (abort || timeout) begin
         state_d  = HUNT;
         stable_d = '0;
         link_d   = 1'b0;
         fv_d     = 1'b0;
         dig_d    = dig_q;
      end
   end

   // p2: FSM state, frame assembly and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= HUNT;
         slot        <= '0;
         settle_cnt  <= '0;
         tmo_cnt     <= '0;
         stable_cnt  <= '0;
         frame_q     <= '0;
         prev_frame  <= {4{DIG_DASH}};
         dig_q       <= {4{DIG_DASH}};
         frame_valid <= 1'b0;
         link_ok     <= 1'b0;
         err_seg     <= 1'b0;
         err_anode   <= 1'b0;
      end else begin
         state       <= state_d;
         slot        <= slot_d;
         settle_cnt  <= settle_d;
         tmo_cnt     <= tmo_d;
         stable_cnt  <= stable_d;
         frame_q     <= frame_d;
         prev_frame  <= prev_d;
         dig_q       <= dig_d;
         frame_valid <= fv_d;
         link_ok     <= link_d;
         err_seg     <= es_d;
         err_anode   <= ea_d;
      end
   end

   assign dig0 = dig_q[0];
   assign dig1 = dig_q[1];
   assign dig2 = dig_q[2];
   assign dig3 = dig_q[3];

`ifdef SEG_RX_ERR_COUNT_EN
   logic [8:0] err_sum;
   assign err_sum = {1'b0, err_count} + 9'(es_d) + 9'(ea_d) + 9'(timeout);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_count <= '0;
      else      err_count <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
   end
`endif

endmodule
